// File: rtl/proc_out_fifo.sv
// -----------------------------------------------------------------------------
// proc_out_fifo
//
// Output-side buffer sitting directly behind the fixed-point processor's IO
// write port. Every processor output write (io_out data tagged with addr_out,
// qualified by out_en) is captured into a circular FIFO and presented on a
// show-ahead valid/ready stream, so a slow consumer (DAC, UART, host bridge)
// can stall without losing processor writes. Writes that arrive while the FIFO
// is full and nothing is leaving are dropped and latched in a sticky overflow
// flag.
//
// Ports:
//   clk       in   1        system clock, rising edge
//   rst       in   1        synchronous, active-low reset
//   io_out    in   NUBITS   processor output data
//   addr_out  in   NAW      processor output address (tag)
//   out_en    in   1        processor output write strobe
//   m_data    out  NUBITS   head-of-FIFO data (0 while empty)
//   m_addr    out  NAW      head-of-FIFO address tag (0 while empty)
//   m_valid   out  1        head word valid
//   m_ready   in   1        consumer accepts head word
//   full      out  1        FIFO holds FDEPTH words
//   count     out  PW+1     stored words, 0..FDEPTH
//   overflow  out  1        sticky: at least one write was dropped
// -----------------------------------------------------------------------------
module proc_out_fifo #(
    parameter int NUBITS = 16,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 8,
    localparam int NAW = $clog2(NUIOOU),
    localparam int PW  = $clog2(FDEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] io_out,
    input  logic [NAW-1:0]    addr_out,
    input  logic              out_en,
    output logic [NUBITS-1:0] m_data,
    output logic [NAW-1:0]    m_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              full,
    output logic [PW:0]       count,
    output logic              overflow
);

    localparam int EW = NAW + NUBITS;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FDEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);

    logic [EW-1:0] mem_q [FDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full_s, valid_s, push_s, pop_s;
    logic [EW-1:0] head_s;

    // Status flags decoded from the registered count, plus the handshake
    // qualifiers. A push into a full FIFO is legal only when a pop frees a slot
    // in the same cycle; there is no path from out_en to m_valid.
    always_comb begin
        full_s  = (count_q == CNT_FULL);
        valid_s = (count_q != CNT_ZERO);
        pop_s   = valid_s && m_ready;
        push_s  = out_en && (!full_s || pop_s);
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A strobe that could not be accepted is a dropped write.
        if (out_en && !push_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers; reset wins over any push or pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            mem_q[wr_ptr_q] <= {addr_out, io_out};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Show-ahead head read, forced to zero while empty so the stream outputs
    // never expose stale or uninitialised storage.
    always_comb begin
        if (valid_s) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = '0;
        end
    end

    assign m_data   = head_s[NUBITS-1:0];
    assign m_addr   = head_s[EW-1:NUBITS];
    assign m_valid  = valid_s;
    assign full     = full_s;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_proc_out_fifo.sv
module tb_proc_out_fifo;

    localparam int NUBITS = 16;
    localparam int NUIOOU = 8;
    localparam int FDEPTH = 8;
    localparam int NAW    = 3;
    localparam int PW     = 3;

    logic              clk;
    logic              rst;
    logic [NUBITS-1:0] io_out;
    logic [NAW-1:0]    addr_out;
    logic              out_en;
    logic [NUBITS-1:0] m_data;
    logic [NAW-1:0]    m_addr;
    logic              m_valid;
    logic              m_ready;
    logic              full;
    logic [PW:0]       count;
    logic              overflow;

    proc_out_fifo #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out),
        .out_en(out_en), .m_data(m_data), .m_addr(m_addr), .m_valid(m_valid),
        .m_ready(m_ready), .full(full), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: {addr, data} of words the reference expects to be stored.
    logic [NAW+NUBITS-1:0] sb[$];
    logic                  ovf_m;
    logic                  stall_prev;
    logic [NUBITS-1:0]     prev_data;
    logic [NAW-1:0]        prev_addr;
    int                    pass_cnt;
    int                    total_cnt;

    typedef struct {
        logic        en;
        logic [15:0] data;
        logic [2:0]  addr;
        logic        rdy;
        logic [3:0]  exp_count;
        logic        exp_valid;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs against the scoreboard,
    // advance the reference model at the edge, then check status outputs.
    task automatic cycle(input logic rst_v, input logic en, input logic [15:0] d,
                         input logic [2:0] a, input logic rdy);
        logic do_pop;
        logic do_push;
        logic [NAW+NUBITS-1:0] exp_e;
        rst = rst_v; out_en = en; io_out = d; addr_out = a; m_ready = rdy;
        #1;
        if (stall_prev) begin
            chk("stable_data", 32'(m_data), 32'(prev_data));
            chk("stable_addr", 32'(m_addr), 32'(prev_addr));
        end
        do_pop  = rst_v && (sb.size() != 0) && rdy;
        do_push = rst_v && en && ((sb.size() < FDEPTH) || do_pop);
        if (do_pop) begin
            exp_e = sb.pop_front();
            chk("pop_data", 32'(m_data), 32'(exp_e[NUBITS-1:0]));
            chk("pop_addr", 32'(m_addr), 32'(exp_e[NAW+NUBITS-1:NUBITS]));
        end
        stall_prev = rst_v && m_valid && !rdy;
        prev_data  = m_data;
        prev_addr  = m_addr;
        @(posedge clk);
        if (!rst_v) begin
            sb.delete();
            ovf_m = 1'b0;
        end else begin
            if (do_push) sb.push_back({a, d});
            if (en && !do_push) ovf_m = 1'b1;
        end
        #1;
        chk("count", 32'(count), 32'(sb.size()));
        chk("m_valid", 32'(m_valid), 32'(sb.size() != 0));
        chk("full", 32'(full), 32'(sb.size() == FDEPTH));
        chk("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    initial begin
        int pushed;
        int guard;

        // Vector table: single word, fill + overflow, drain.
        vecs[0] = '{1'b1, 16'h1234, 3'd3, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            vecs[2+i] = '{1'b1, 16'(i + 1), 3'(i), 1'b0, 4'(i + 1), 1'b1,
                          (i == 7), 1'b0};
        end
        vecs[10] = '{1'b1, 16'd9, 3'd0, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            vecs[11+i] = '{1'b0, 16'h0000, 3'd0, 1'b1, 4'(7 - i), (i != 7),
                           1'b0, 1'b1};
        end

        pass_cnt = 0; total_cnt = 0; ovf_m = 1'b0; stall_prev = 1'b0;
        rst = 1'b0; out_en = 1'b0; io_out = '0; addr_out = '0; m_ready = 1'b0;

        // Reset hold with out_en active.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'hAAAA, 3'd5, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_addr", 32'(m_addr), 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 19; i++) begin
            cycle(1'b1, vecs[i].en, vecs[i].data, vecs[i].addr, vecs[i].rdy);
            chk("vec_count", 32'(count), 32'(vecs[i].exp_count));
            chk("vec_valid", 32'(m_valid), 32'(vecs[i].exp_valid));
            chk("vec_full", 32'(full), 32'(vecs[i].exp_full));
            chk("vec_ovf", 32'(overflow), 32'(vecs[i].exp_ovf));
            if (i == 0) begin
                chk("single_data", 32'(m_data), 32'h1234);
                chk("single_addr", 32'(m_addr), 32'd3);
            end
        end

        // Full FIFO with simultaneous push and pop.
        cycle(1'b0, 1'b0, 16'h0, 3'd0, 1'b0);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'(i + 1), 3'(i + 2), 1'b0);
        chk("full_before", 32'(full), 32'd1);
        chk("head_is_1", 32'(m_data), 32'd1);
        cycle(1'b1, 1'b1, 16'd9, 3'd1, 1'b1);
        chk("pp_count", 32'(count), 32'd8);
        chk("pp_ovf", 32'(overflow), 32'd0);
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            cycle(1'b1, 1'b0, 16'h0, 3'd0, 1'b1);
            guard++;
        end
        chk("pp_drained", 32'(count), 32'd0);

        // Wrap with pseudo-random backpressure, never overflowing.
        pushed = 0;
        guard  = 0;
        while (pushed < 40 && guard < 2000) begin
            if (sb.size() < FDEPTH) begin
                cycle(1'b1, 1'b1, 16'(16'h0100 + pushed), 3'(pushed * 3),
                      1'($urandom_range(0, 1)));
                pushed++;
            end else begin
                cycle(1'b1, 1'b0, 16'h0, 3'd0, 1'($urandom_range(0, 1)));
            end
            guard++;
        end
        chk("wrap_pushed", 32'(pushed), 32'd40);
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            cycle(1'b1, 1'b0, 16'h0, 3'd0, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("wrap_drained", 32'(sb.size()), 32'd0);
        chk("wrap_ovf", 32'(overflow), 32'd0);

        // Reset mid-operation.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 16'(16'h0500 + i), 3'(i), 1'b0);
        chk("mid_count5", 32'(count), 32'd5);
        cycle(1'b0, 1'b1, 16'hDEAD, 3'd7, 1'b1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        cycle(1'b1, 1'b1, 16'hBEEF, 3'd6, 1'b0);
        chk("mid_first_data", 32'(m_data), 32'hBEEF);
        chk("mid_first_addr", 32'(m_addr), 32'd6);
        cycle(1'b1, 1'b0, 16'h0, 3'd0, 1'b1);
        chk("mid_empty", 32'(m_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
